// File: rtl/ibex_trace_buf_pkg.sv
// Shared types for the retired-instruction trace buffer: record layout,
// capture modes and capture FSM states.
package ibex_trace_buf_pkg;

  // Record timestamp field is fixed width; narrower counters are zero-extended into it.
  localparam int unsigned TraceTsW = 32;

  typedef struct packed {
    logic [TraceTsW-1:0] ts;
    logic [31:0]         pc;
    logic [31:0]         insn;
    logic [4:0]          rd_addr;
    logic [31:0]         rd_wdata;
    logic                trap;
  } trace_rec_t;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_WRAP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } trace_state_e;

endpackage

// File: rtl/ibex_trace_buf_ram.sv
// Flop-array storage for trace records: one synchronous write port and one
// asynchronous read port. Data is deliberately left unreset.
module ibex_trace_buf_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  localparam int unsigned AW   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ibex_trace_buf.sv
// On-chip capture buffer for RVFI retirement records with STOP, WRAP and
// PC-triggered capture modes, drained through a first-word-fall-through port.
module ibex_trace_buf
  import ibex_trace_buf_pkg::*;
#(
  parameter int unsigned Depth      = 16,
  parameter int unsigned TimestampW = 32,
  parameter int unsigned DropCntW   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_en_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [31:0]              cfg_trig_pc_i,
  input  logic                     clear_i,
  input  logic                     rvfi_valid_i,
  input  logic [31:0]              rvfi_pc_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic                     rvfi_trap_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output trace_rec_t               rd_rec_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     overflow_o,
  output logic [DropCntW-1:0]      drop_cnt_o,
  output logic [1:0]               state_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RecW = $bits(trace_rec_t);

  trace_state_e          state_q;
  trace_mode_e           mode_q, mode_eff;
  logic                  en_q, en_rise, trig_hit;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [TimestampW-1:0] ts_q;
  logic                  overflow_q;
  logic [DropCntW-1:0]   drop_cnt_q;
  logic                  empty, full, push, pop, wrap_mode;
  logic                  drop_evt, do_write, rptr_inc;
  trace_rec_t            rec_in;
  logic [RecW-1:0]       ram_rdata;

  assign en_rise   = cfg_en_i & ~en_q;
  assign mode_eff  = en_rise ? trace_mode_e'(cfg_mode_i) : mode_q;
  assign trig_hit  = rvfi_valid_i && (rvfi_pc_i == cfg_trig_pc_i);
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wrap_mode = (mode_q == MODE_WRAP);

  // The triggering instruction is captured in the same cycle that leaves ARMED.
  assign push = ~clear_i & rvfi_valid_i &
                ((state_q == CAPTURE) | ((state_q == ARMED) & trig_hit));
  assign pop  = ~clear_i & rd_ready_i & ~empty;

  assign drop_evt = push & full & ~pop;
  assign do_write = push & (~full | pop | wrap_mode);
  assign rptr_inc = pop | (drop_evt & wrap_mode);

  assign rec_in = '{
    ts:       TraceTsW'(ts_q),
    pc:       rvfi_pc_i,
    insn:     rvfi_insn_i,
    rd_addr:  rvfi_rd_addr_i,
    rd_wdata: rvfi_rd_wdata_i,
    trap:     rvfi_trap_i
  };

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= MODE_STOP;
      en_q    <= 1'b0;
    end else begin
      en_q <= cfg_en_i;
      if (en_rise) begin
        mode_q <= trace_mode_e'(cfg_mode_i);
      end
      if (!cfg_en_i) begin
        state_q <= IDLE;
      end else if (clear_i || en_rise) begin
        state_q <= (mode_eff == MODE_TRIG) ? ARMED : CAPTURE;
      end else if ((state_q == ARMED) && trig_hit) begin
        state_q <= CAPTURE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clear_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (do_write) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (rptr_inc) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (drop_evt) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  ibex_trace_buf_ram #(
    .Depth (Depth),
    .Width (RecW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (do_write),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (rec_in),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Head is masked when empty so unwritten storage never leaks out after reset.
  assign rd_rec_o   = empty ? '0 : trace_rec_t'(ram_rdata);
  assign rd_valid_o = ~empty;
  assign level_o    = wptr_q - rptr_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ibex_trace_buf.sv
// Self-checking bench for ibex_trace_buf: a queue-based reference model is
// compared every cycle, plus directed literal checks for each capture scenario.
module tb_ibex_trace_buf;
  import ibex_trace_buf_pkg::*;

  localparam int DEPTH = 16;

  logic        clk, rst_n;
  logic        cfg_en, clear, rvfi_valid, rvfi_trap, rd_ready;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_trig_pc, rvfi_pc, rvfi_insn, rvfi_rd_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic        rd_valid_o, overflow_o;
  trace_rec_t  rd_rec_o;
  logic [4:0]  level_o;
  logic [15:0] drop_cnt_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  ibex_trace_buf #(.Depth(DEPTH), .TimestampW(32), .DropCntW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_mode_i(cfg_mode),
    .cfg_trig_pc_i(cfg_trig_pc), .clear_i(clear), .rvfi_valid_i(rvfi_valid),
    .rvfi_pc_i(rvfi_pc), .rvfi_insn_i(rvfi_insn), .rvfi_rd_addr_i(rvfi_rd_addr),
    .rvfi_rd_wdata_i(rvfi_rd_wdata), .rvfi_trap_i(rvfi_trap),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_rec_o(rd_rec_o),
    .level_o(level_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a record queue plus counters, updated from the observed inputs.
  trace_rec_t   m_q[$];
  trace_rec_t   m_rec;
  logic         m_ovf, m_en_prev, m_rise, m_hit, m_cap;
  logic [15:0]  m_drop;
  logic [31:0]  m_ts;
  logic [1:0]   m_mode, m_mode_now;
  trace_state_e m_state;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 1'b0; m_drop = '0; m_state = IDLE; m_mode = 2'd0;
      m_en_prev = 1'b0; m_ts = '0;
    end else begin
      m_rise     = cfg_en && !m_en_prev;
      m_mode_now = m_rise ? cfg_mode : m_mode;
      m_hit      = rvfi_valid && (rvfi_pc == cfg_trig_pc);
      m_cap      = rvfi_valid && (m_state == CAPTURE || (m_state == ARMED && m_hit));
      if (clear) begin
        m_q.delete();
        m_ovf = 1'b0; m_drop = '0;
      end else begin
        if (rd_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (m_cap) begin
          m_rec = '{ts: m_ts, pc: rvfi_pc, insn: rvfi_insn, rd_addr: rvfi_rd_addr,
                    rd_wdata: rvfi_rd_wdata, trap: rvfi_trap};
          if (m_q.size() < DEPTH) m_q.push_back(m_rec);
          else begin
            if (m_mode == 2'd1) begin
              void'(m_q.pop_front());
              m_q.push_back(m_rec);
            end
            m_ovf = 1'b1;
            if (m_drop != 16'hffff) m_drop = m_drop + 16'd1;
          end
        end
      end
      if (!cfg_en) m_state = IDLE;
      else if (clear || m_rise) m_state = (m_mode_now == 2'd2) ? ARMED : CAPTURE;
      else if (m_state == ARMED && m_hit) m_state = CAPTURE;
      if (m_rise) m_mode = cfg_mode;
      m_en_prev = cfg_en;
      m_ts = m_ts + 32'd1;
    end
  end

  always @(negedge clk) begin
    checkOutput("level", level_o, m_q.size());
    checkOutput("rd_valid", rd_valid_o, m_q.size() != 0);
    checkOutput("overflow", overflow_o, m_ovf);
    checkOutput("drop_cnt", drop_cnt_o, m_drop);
    checkOutput("state", state_o, m_state);
    if (m_q.size() != 0) checkOutput("rd_rec", rd_rec_o, m_q[0]);
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy);
    @(posedge clk); #2;
    rvfi_valid    = v;
    rvfi_pc       = pc;
    rvfi_insn     = ~pc;
    rvfi_rd_addr  = pc[6:2];
    rvfi_rd_wdata = pc + 32'h1111;
    rvfi_trap     = pc[3];
    rd_ready      = rdy;
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] mode);
    @(posedge clk); #2;
    cfg_en = en; cfg_mode = mode; rvfi_valid = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic pop_expect(input logic [31:0] exp_pc);
    @(posedge clk); #2;
    rvfi_valid = 1'b0; rd_ready = 1'b1;
    #1 checkOutput("pop_pc", rd_rec_o.pc, exp_pc);
  endtask

  task automatic flush_buffer();
    set_cfg(1'b0, 2'd0);
    @(posedge clk); #2 clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0;
    @(negedge clk);
    checkOutput("flush_drop", drop_cnt_o, 16'd0);
    checkOutput("flush_level", level_o, 5'd0);
  endtask

  initial begin
    rst_n = 1'b1; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_trig_pc = '0; clear = 1'b0;
    rvfi_valid = 1'b0; rvfi_pc = '0; rvfi_insn = '0; rvfi_rd_addr = '0;
    rvfi_rd_wdata = '0; rvfi_trap = 1'b0; rd_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_level", level_o, 5'd0);
    checkOutput("rst_valid", rd_valid_o, 1'b0);
    checkOutput("rst_state", state_o, 2'd0);
    checkOutput("rst_drop", drop_cnt_o, 16'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // STOP: overflow drops the newest four
    set_cfg(1'b1, 2'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t1_level", level_o, 5'd16);
    checkOutput("t1_drop", drop_cnt_o, 16'd4);
    checkOutput("t1_ovf", overflow_o, 1'b1);
    for (int i = 0; i < 16; i++) pop_expect(32'h1000 + 32'(4 * i));
    applyStimulus(1'b0, '0, 1'b1);
    @(negedge clk);
    checkOutput("t1_empty", rd_valid_o, 1'b0);
    flush_buffer();

    // WRAP: keeps newest sixteen; later mode change must be ignored
    set_cfg(1'b1, 2'd1);
    @(posedge clk); #2 cfg_mode = 2'd0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h2000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t2_level", level_o, 5'd16);
    checkOutput("t2_drop", drop_cnt_o, 16'd4);
    for (int i = 0; i < 16; i++) pop_expect(32'h2000 + 32'(4 * (i + 4)));
    flush_buffer();

    // TRIG: capture starts at the matching PC
    cfg_trig_pc = 32'h8000_0040;
    set_cfg(1'b1, 2'd2);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t3_armed", state_o, 2'd1);
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t3_capture", state_o, 2'd2);
    checkOutput("t3_level", level_o, 5'd2);
    pop_expect(32'h8000_0040);
    pop_expect(32'h8000_0044);
    flush_buffer();

    // Full with simultaneous push and pop, then clear against push and pop
    set_cfg(1'b1, 2'd0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h3040 + 32'(4 * i), 1'b1);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t4_level", level_o, 5'd16);
    checkOutput("t4_ovf", overflow_o, 1'b0);
    checkOutput("t4_head", rd_rec_o.pc, 32'h3028);
    applyStimulus(1'b1, 32'h4000, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t5_pre_drop", drop_cnt_o, 16'd1);
    applyStimulus(1'b1, 32'h4004, 1'b1);
    clear = 1'b1;
    @(posedge clk); #2 clear = 1'b0; rvfi_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    checkOutput("t5_level", level_o, 5'd0);
    checkOutput("t5_valid", rd_valid_o, 1'b0);
    checkOutput("t5_drop", drop_cnt_o, 16'd0);

    // Reset mid-capture with seven records held
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 32'h5000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t6_level7", level_o, 5'd7);
    @(posedge clk); #2;
    rst_n = 1'b0; cfg_en = 1'b0;
    #1;
    checkOutput("t6_level", level_o, 5'd0);
    checkOutput("t6_valid", rd_valid_o, 1'b0);
    checkOutput("t6_state", state_o, 2'd0);
    checkOutput("t6_ovf", overflow_o, 1'b0);
    checkOutput("t6_rec", rd_rec_o, '0);
    @(posedge clk); #2 rst_n = 1'b1;
    set_cfg(1'b1, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h6000 + 32'(4 * i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    checkOutput("t6_relevel", level_o, 5'd3);
    pop_expect(32'h6000);
    applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
